// File: rtl/spi_slave_fsm_if.sv
// Bus bundle between the SPI slave front end and its master-side neighbours
// (SPI pins toward the host, word/strobe/read-data signals toward the RAM controller).
interface spi_slave_fsm_if #(
    parameter int RX_WIDTH = 10,
    parameter int TX_WIDTH = 8
);
    logic                SS_n;
    logic                MOSI;
    logic                MISO;
    logic [RX_WIDTH-1:0] rx_data;
    logic                rx_valid;
    logic [TX_WIDTH-1:0] tx_data;
    logic                tx_valid;

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid
    );

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
        output MISO, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_slave_fsm.sv
// SPI slave serial front end: deserialises MOSI frames into command/address/data
// words for the RAM controller and serialises read data back out on MISO.
module spi_slave_fsm #(
    parameter int RX_WIDTH = 10,
    parameter int TX_WIDTH = 8
) (
    input logic             clk,
    input logic             rst_n,
    spi_slave_fsm_if.slave  bus
);
    localparam int MAX_W = (RX_WIDTH > TX_WIDTH) ? RX_WIDTH : TX_WIDTH;
    localparam int CNT_W = $clog2(MAX_W + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    // Sub-phase within a receive state; only READ_DATA goes past PH_RX into transmit.
    typedef enum logic [1:0] {
        PH_RX   = 2'd0,
        PH_WAIT = 2'd1,
        PH_TX   = 2'd2,
        PH_END  = 2'd3
    } phase_t;

    state_t              state_r, state_s;
    phase_t              phase_r, phase_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    // Holds the first RX_WIDTH-1 bits; the last bit comes straight from MOSI.
    logic [RX_WIDTH-2:0] shift_r, shift_s;
    logic [TX_WIDTH-1:0] tx_shift_r, tx_shift_s;
    logic [RX_WIDTH-1:0] rx_data_r, rx_data_s;
    logic                rx_valid_r, rx_valid_s;
    logic                miso_r, miso_s;
    logic                rd_addr_done_r, rd_addr_done_s;
    logic [RX_WIDTH-1:0] word_s;

    assign word_s       = {shift_r, bus.MOSI};
    assign bus.MISO     = miso_r;
    assign bus.rx_data  = rx_data_r;
    assign bus.rx_valid = rx_valid_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; SS_n high from any active state aborts the frame.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (!bus.SS_n) begin
                    state_s = CHK_CMD;
                end else begin
                    state_s = IDLE;
                end
            end
            CHK_CMD: begin
                if (bus.SS_n) begin
                    state_s = IDLE;
                end else if (!bus.MOSI) begin
                    state_s = WRITE;
                end else if (rd_addr_done_r) begin
                    state_s = READ_DATA;
                end else begin
                    state_s = READ_ADD;
                end
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (bus.SS_n) begin
                    state_s = IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Datapath next values: shifting, word capture, strobe and MISO serialisation.
    always_comb begin
        phase_s        = phase_r;
        cnt_s          = cnt_r;
        shift_s        = shift_r;
        tx_shift_s     = tx_shift_r;
        rx_data_s      = rx_data_r;
        rx_valid_s     = 1'b0;
        miso_s         = 1'b0;
        rd_addr_done_s = rd_addr_done_r;
        if (state_r == IDLE || bus.SS_n) begin
            phase_s    = PH_RX;
            cnt_s      = {CNT_W{1'b0}};
            shift_s    = {(RX_WIDTH-1){1'b0}};
            tx_shift_s = {TX_WIDTH{1'b0}};
        end else if (state_r == CHK_CMD) begin
            phase_s = PH_RX;
            cnt_s   = {CNT_W{1'b0}};
            shift_s = {(RX_WIDTH-1){1'b0}};
        end else begin
            case (phase_r)
                PH_RX: begin
                    shift_s = word_s[RX_WIDTH-2:0];
                    if (cnt_r == CNT_W'(RX_WIDTH - 1)) begin
                        rx_data_s  = word_s;
                        rx_valid_s = 1'b1;
                        cnt_s      = {CNT_W{1'b0}};
                        if (state_r == READ_ADD) begin
                            rd_addr_done_s = 1'b1;
                        end else if (state_r == READ_DATA) begin
                            rd_addr_done_s = 1'b0;
                        end else begin
                            rd_addr_done_s = rd_addr_done_r;
                        end
                        if (state_r == READ_DATA) begin
                            phase_s = PH_WAIT;
                        end else begin
                            phase_s = PH_END;
                        end
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                PH_WAIT: begin
                    if (bus.tx_valid) begin
                        tx_shift_s = {bus.tx_data[TX_WIDTH-2:0], 1'b0};
                        miso_s     = bus.tx_data[TX_WIDTH-1];
                        cnt_s      = CNT_W'(1);
                        phase_s    = PH_TX;
                    end else begin
                        phase_s = PH_WAIT;
                    end
                end
                PH_TX: begin
                    if (cnt_r < CNT_W'(TX_WIDTH)) begin
                        miso_s     = tx_shift_r[TX_WIDTH-1];
                        tx_shift_s = {tx_shift_r[TX_WIDTH-2:0], 1'b0};
                        cnt_s      = cnt_r + CNT_W'(1);
                    end else begin
                        phase_s = PH_END;
                    end
                end
                PH_END:  phase_s = PH_END;
                default: phase_s = PH_END;
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_r        <= PH_RX;
            cnt_r          <= {CNT_W{1'b0}};
            shift_r        <= {(RX_WIDTH-1){1'b0}};
            tx_shift_r     <= {TX_WIDTH{1'b0}};
            rx_data_r      <= {RX_WIDTH{1'b0}};
            rx_valid_r     <= 1'b0;
            miso_r         <= 1'b0;
            rd_addr_done_r <= 1'b0;
        end else begin
            phase_r        <= phase_s;
            cnt_r          <= cnt_s;
            shift_r        <= shift_s;
            tx_shift_r     <= tx_shift_s;
            rx_data_r      <= rx_data_s;
            rx_valid_r     <= rx_valid_s;
            miso_r         <= miso_s;
            rd_addr_done_r <= rd_addr_done_s;
        end
    end
endmodule

// File: tb/tb_spi_slave_fsm.sv
// Scoreboard bench for spi_slave_fsm: expected rx words are queued by the stimulus
// and popped by a monitor on every rx_valid strobe; MISO/routing checked inline.
module tb_spi_slave_fsm;
    localparam int RXW = 10;
    localparam int TXW = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [RXW-1:0] exp_q[$];
    logic prev_valid;

    spi_slave_fsm_if #(.RX_WIDTH(RXW), .TX_WIDTH(TXW)) bus ();

    spi_slave_fsm #(.RX_WIDTH(RXW), .TX_WIDTH(TXW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest queued word, never back-to-back.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.rx_valid === 1'b1) begin
                check("rx_valid_not_consecutive", {31'd0, prev_valid}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_rx_valid", {22'd0, bus.rx_data}, 32'hFFFF_FFFF);
                end else begin
                    check("rx_data", {22'd0, bus.rx_data}, {22'd0, exp_q.pop_front()});
                end
            end
            prev_valid = bus.rx_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    // Frame start (IDLE->CHK_CMD, command bit) followed by n data bits MSB first.
    task automatic send_bits(input logic cmd, input logic [RXW-1:0] w, input int n);
        bus.SS_n = 1'b0;
        bus.MOSI = cmd;
        @(negedge clk);
        bus.MOSI = cmd;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            bus.MOSI = w[RXW-1-i];
            @(negedge clk);
        end
    endtask

    task automatic end_frame();
        bus.SS_n = 1'b1;
        bus.MOSI = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [TXW-1:0] tx_pat;
        checks = 0;
        errors = 0;
        prev_valid = 1'b0;
        rst_n = 1'b0;
        bus.SS_n = 1'b1;
        bus.MOSI = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data = 8'h00;
        repeat (2) @(negedge clk);
        check("reset_miso", {31'd0, bus.MISO}, 32'd0);
        check("reset_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        check("reset_rx_data", {22'd0, bus.rx_data}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write address
        exp_q.push_back(10'h0A5);
        send_bits(1'b0, 10'h0A5, 10);
        @(negedge clk);
        check("wr_addr_rd_done", {31'd0, dut.rd_addr_done_r}, 32'd0);
        end_frame();

        // Write data, with extra ignored bits after the word
        exp_q.push_back(10'h0C3);
        send_bits(1'b0, 10'h0C3, 10);
        bus.MOSI = 1'b1;
        repeat (3) @(negedge clk);
        end_frame();
        check("idle_after_ss", {29'd0, dut.state_r}, 32'd0);
        check("idle_miso", {31'd0, bus.MISO}, 32'd0);

        // Read address then read data with transmit
        exp_q.push_back(10'h255);
        send_bits(1'b1, 10'h255, 10);
        check("rd_addr_done_set", {31'd0, dut.rd_addr_done_r}, 32'd1);
        end_frame();
        exp_q.push_back(10'h300);
        send_bits(1'b1, 10'h300, 10);
        check("rd_addr_done_clr", {31'd0, dut.rd_addr_done_r}, 32'd0);
        tx_pat = 8'hB4;
        bus.tx_data = tx_pat;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_data = 8'h00;
        for (int i = 0; i < TXW; i++) begin
            check("miso_bit", {31'd0, bus.MISO}, {31'd0, tx_pat[TXW-1-i]});
            @(negedge clk);
        end
        check("miso_after_tx", {31'd0, bus.MISO}, 32'd0);
        bus.tx_valid = 1'b0;
        end_frame();
        check("miso_idle_after_read", {31'd0, bus.MISO}, 32'd0);

        // Abort after 6 write bits
        send_bits(1'b0, 10'h3FF, 6);
        end_frame();
        check("abort_rx_data_held", {22'd0, bus.rx_data}, 32'h300);
        exp_q.push_back(10'h012);
        send_bits(1'b0, 10'h012, 10);
        end_frame();

        // SS_n rises on the edge that samples the last bit: word discarded
        send_bits(1'b0, 10'h155, 9);
        bus.SS_n = 1'b1;
        bus.MOSI = 1'b1;
        repeat (2) @(negedge clk);
        check("last_bit_abort_held", {22'd0, bus.rx_data}, 32'h012);

        // Read-data routing survives an aborted read frame
        exp_q.push_back(10'h111);
        send_bits(1'b1, 10'h111, 10);
        end_frame();
        send_bits(1'b1, 10'h2AB, 4);
        end_frame();
        check("routing_rd_done_kept", {31'd0, dut.rd_addr_done_r}, 32'd1);
        exp_q.push_back(10'h2AB);
        send_bits(1'b1, 10'h2AB, 10);
        check("routing_read_data", {29'd0, dut.state_r}, 32'd4);

        // Async reset mid-transmit
        bus.tx_data = 8'hFF;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("miso_before_reset", {31'd0, bus.MISO}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_miso", {31'd0, bus.MISO}, 32'd0);
        check("arst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        check("arst_state", {29'd0, dut.state_r}, 32'd0);
        check("arst_rd_done", {31'd0, dut.rd_addr_done_r}, 32'd0);
        bus.SS_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
